dmem_responder: RTL



---
 rtl/dmem_responder_pkg.sv | 33 +++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access length codes, FSM states,
// and the byte-count / word-split helpers.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        LEN_NONE = 2'b00,
        LEN_BYTE = 2'b01,
        LEN_HALF = 2'b10,
        LEN_WORD = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_RESP
    } state_e;

    function automatic logic [2:0] len_bytes(input len_e len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            LEN_WORD: len_bytes = 3'd4;
            default:  len_bytes = 3'd0;
        endcase
    endfunction

    // An access needs a second word when its last byte lies past lane 3.
    function automatic logic is_split(input logic [1:0] offset, input len_e len);
        is_split = ({1'b0, offset} + len_bytes(len)) > 3'd4;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the data-path (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_length;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_length, req_signed, req_address, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_length, req_signed, req_address, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: merges store bytes into a word pair and
// extracts/extends load bytes from it, little-endian, starting at offset_i.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  len_e        len_i,
    input  logic        signed_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] wr_word0_o,
    output logic [31:0] wr_word1_o,
    output logic [31:0] rdata_o
);
    logic [63:0] pair;
    logic [63:0] wr_data;
    logic [63:0] wr_mask;
    logic [31:0] shifted;
    logic [7:0]  byte_en;
    logic [5:0]  shamt;

    // NOTE: every output and temporary gets a value on every path so no latch is inferred.
    always_comb begin
        pair    = {word1_i, word0_i};
        shamt   = {offset_i, 3'b000};
        shifted = 32'(pair >> shamt);

        case (len_i)
            LEN_BYTE: rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            LEN_HALF: rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            LEN_WORD: rdata_o = shifted;
            default:  rdata_o = 32'd0;
        endcase

        byte_en = ((8'd1 << len_bytes(len_i)) - 8'd1) << offset_i;
        for (int b = 0; b < 8; b++) begin
            wr_mask[b*8 +: 8] = {8{byte_en[b]}};
        end
        wr_data = {32'd0, wdata_i} << shamt;
        {wr_word1_o, wr_word0_o} = (pair & ~wr_mask) | (wr_data & wr_mask);
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory with byte/half/word access and split
// misaligned beats. Define DMEM_ALIGN_TRAP_EN to fault misaligned accesses instead.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_STATES);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            write_q;
    logic            signed_q;
    logic            split_q;
    len_e            len_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     word0_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            rsp_error_q;
    logic [31:0]     rsp_rdata_q;

    logic [31:0]     mem [DEPTH_WORDS];

    len_e            len_in;
    logic            trap_c;
    logic [AW-1:0]   idx0;
    logic [AW-1:0]   idx1;
    logic [31:0]     beat_word0;
    logic [31:0]     wr_word0;
    logic [31:0]     wr_word1;
    logic [31:0]     rd_data;
    logic            commit;

    assign len_in     = len_e'(bus.req_length);
    assign idx0       = addr_q[AW+1:2];
    assign idx1       = idx0 + 1'b1;
    assign beat_word0 = (state_q == ST_BEAT0) ? mem[idx0] : word0_q;
    assign commit     = (cnt_q == '0) &&
                        ((state_q == ST_BEAT0 && !split_q) || state_q == ST_BEAT1);

    always_comb begin
`ifdef DMEM_ALIGN_TRAP_EN
        trap_c = (len_in == LEN_HALF && bus.req_address[0]) ||
                 (len_in == LEN_WORD && bus.req_address[1:0] != 2'b00);
`else
        trap_c = 1'b0;
`endif
    end

    dmem_lane_align u_lane_align (
        .offset_i   (addr_q[1:0]),
        .len_i      (len_q),
        .signed_i   (signed_q),
        .word0_i    (beat_word0),
        .word1_i    (mem[idx1]),
        .wdata_i    (wdata_q),
        .wr_word0_o (wr_word0),
        .wr_word1_o (wr_word1),
        .rdata_o    (rd_data)
    );

    // NOTE: the array is deliberately left out of reset; both store beats land together on commit.
    always_ff @(posedge SYS_clk) begin
        if (commit && write_q) begin
            mem[idx0] <= wr_word0;
            if (split_q) mem[idx1] <= wr_word1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            split_q     <= 1'b0;
            len_q       <= LEN_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            word0_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q     <= bus.req_write;
                        signed_q    <= bus.req_signed;
                        len_q       <= len_in;
                        addr_q      <= bus.req_address[AW+1:0];
                        wdata_q     <= bus.req_wdata;
                        split_q     <= is_split(bus.req_address[1:0], len_in);
                        cnt_q       <= WAIT_INIT;
                        req_ready_q <= 1'b0;
                        if (trap_c || len_in == LEN_NONE) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= trap_c;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= ST_BEAT0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (split_q) begin
                        word0_q <= beat_word0;
                        cnt_q   <= WAIT_INIT;
                        state_q <= ST_BEAT1;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? 32'd0 : rd_data;
                    end
                end
                ST_BEAT1: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? 32'd0 : rd_data;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule
